// File: rtl/param_instr_ram_if.sv
// Fetch, streaming-load and direct-write bus of the Galetron instruction memory.
// master drives requests into the memory; slave is the memory side.
interface param_instr_ram_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  fetch_en;
    logic [ADDR_WIDTH-1:0] fetch_address;
    logic [DATA_WIDTH-1:0] fetch_data;
    logic                  fetch_valid;

    logic                  load_start;
    logic [ADDR_WIDTH-1:0] load_base;
    logic [ADDR_WIDTH:0]   load_count;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_valid;
    logic                  load_ready;
    logic                  load_done;

    logic [ADDR_WIDTH-1:0] i_ram_writing_address;
    logic [DATA_WIDTH-1:0] i_ram_input;
    logic                  flag_write_i_ram;

    logic                  ram_ready;
    logic                  addr_error;

    modport master (
        output fetch_en, fetch_address,
        output load_start, load_base, load_count, load_data, load_valid,
        output i_ram_writing_address, i_ram_input, flag_write_i_ram,
        input  fetch_data, fetch_valid, load_ready, load_done, ram_ready, addr_error
    );

    modport slave (
        input  fetch_en, fetch_address,
        input  load_start, load_base, load_count, load_data, load_valid,
        input  i_ram_writing_address, i_ram_input, flag_write_i_ram,
        output fetch_data, fetch_valid, load_ready, load_done, ram_ready, addr_error
    );
endinterface

// File: rtl/param_instr_ram.sv
// Galetron instruction memory: NOP clear sweep, streaming loader, direct write, 1-cycle fetch.
// Define FETCH_BYPASS_EN to forward same-cycle write data to the fetch port.
module param_instr_ram #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    DEPTH      = 1024,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = 32'h6C000000
) (
    input  logic               clock,
    input  logic               reset_n,
    param_instr_ram_if.slave   bus
);
    localparam int                    IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned           LAST     = DEPTH - 1;
    localparam logic [IDX_W-1:0]      LAST_IDX = LAST[IDX_W-1:0];
    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   ONE_W    = (ADDR_WIDTH+1)'(1);

    typedef enum logic [1:0] {ST_CLEAR, ST_RUN, ST_LOAD} state_t;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    state_t                state_reg;
    logic [IDX_W-1:0]      clear_ptr_reg;
    logic [IDX_W-1:0]      load_ptr_reg;
    logic [ADDR_WIDTH:0]   remaining_reg;
    logic                  fetch_valid_reg;
    logic                  load_ready_reg;
    logic                  load_done_reg;
    logic                  ram_ready_reg;
    logic                  addr_error_reg;
    logic                  nop_sel_reg;
    logic [DATA_WIDTH-1:0] ram_q_reg;

    logic                  in_run;
    logic                  fetch_in_range;
    logic                  wr_addr_in_range;
    logic                  base_in_range;
    logic                  fetch_fire;
    logic                  rd_en;
    logic [IDX_W-1:0]      rd_idx;
    logic                  load_fire;
    logic                  direct_fire;
    logic                  wr_en;
    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;

    assign in_run           = (state_reg == ST_RUN);
    assign fetch_in_range   = ({1'b0, bus.fetch_address} < DEPTH_W);
    assign wr_addr_in_range = ({1'b0, bus.i_ram_writing_address} < DEPTH_W);
    assign base_in_range    = ({1'b0, bus.load_base} < DEPTH_W);
    assign fetch_fire       = in_run & bus.fetch_en;
    assign rd_en            = fetch_fire & fetch_in_range;
    assign rd_idx           = bus.fetch_address[IDX_W-1:0];
    assign load_fire        = (state_reg == ST_LOAD) & bus.load_valid & load_ready_reg;
    assign direct_fire      = in_run & bus.flag_write_i_ram & wr_addr_in_range;

    // Single write port shared by the sweep, the loader and the direct port.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = '0;
        if (state_reg == ST_CLEAR) begin
            wr_en   = 1'b1;
            wr_idx  = clear_ptr_reg;
            wr_data = NOP_WORD;
        end else if (load_fire) begin
            wr_en   = 1'b1;
            wr_idx  = load_ptr_reg;
            wr_data = bus.load_data;
        end else if (direct_fire) begin
            wr_en   = 1'b1;
            wr_idx  = bus.i_ram_writing_address[IDX_W-1:0];
            wr_data = bus.i_ram_input;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (rd_en) begin
            ram_q_reg <= mem[rd_idx];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_CLEAR;
            clear_ptr_reg   <= '0;
            load_ptr_reg    <= '0;
            remaining_reg   <= '0;
            fetch_valid_reg <= 1'b0;
            load_ready_reg  <= 1'b0;
            load_done_reg   <= 1'b0;
            ram_ready_reg   <= 1'b0;
            addr_error_reg  <= 1'b0;
            nop_sel_reg     <= 1'b1;
        end else begin
            load_done_reg   <= 1'b0;
            fetch_valid_reg <= fetch_fire;
            // nop_sel_reg only moves on a fetch so fetch_data holds otherwise.
            if (fetch_fire) begin
                nop_sel_reg <= ~fetch_in_range;
                if (!fetch_in_range) begin
                    addr_error_reg <= 1'b1;
                end
            end
            case (state_reg)
                ST_CLEAR: begin
                    clear_ptr_reg <= clear_ptr_reg + 1'b1;
                    if (clear_ptr_reg == LAST_IDX) begin
                        clear_ptr_reg <= '0;
                        state_reg     <= ST_RUN;
                        ram_ready_reg <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.flag_write_i_ram && !wr_addr_in_range) begin
                        addr_error_reg <= 1'b1;
                    end
                    if (bus.load_start) begin
                        if (!base_in_range) begin
                            addr_error_reg <= 1'b1;
                            load_done_reg  <= 1'b1;
                        end else if (bus.load_count == '0) begin
                            load_done_reg <= 1'b1;
                        end else begin
                            load_ptr_reg   <= bus.load_base[IDX_W-1:0];
                            remaining_reg  <= bus.load_count;
                            state_reg      <= ST_LOAD;
                            ram_ready_reg  <= 1'b0;
                            load_ready_reg <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (load_fire) begin
                        load_ptr_reg  <= (load_ptr_reg == LAST_IDX) ? '0 : load_ptr_reg + 1'b1;
                        remaining_reg <= remaining_reg - ONE_W;
                        if (remaining_reg == ONE_W) begin
                            state_reg      <= ST_RUN;
                            ram_ready_reg  <= 1'b1;
                            load_ready_reg <= 1'b0;
                            load_done_reg  <= 1'b1;
                        end
                    end
                end
                default: state_reg <= ST_CLEAR;
            endcase
        end
    end

`ifdef FETCH_BYPASS_EN
    logic                  byp_sel_reg;
    logic [DATA_WIDTH-1:0] byp_data_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            byp_sel_reg  <= 1'b0;
            byp_data_reg <= '0;
        end else if (fetch_fire) begin
            byp_sel_reg  <= rd_en & wr_en & (wr_idx == rd_idx);
            byp_data_reg <= wr_data;
        end
    end

    assign bus.fetch_data = nop_sel_reg ? NOP_WORD : (byp_sel_reg ? byp_data_reg : ram_q_reg);
`else
    assign bus.fetch_data = nop_sel_reg ? NOP_WORD : ram_q_reg;
`endif

    assign bus.fetch_valid = fetch_valid_reg;
    assign bus.load_ready  = load_ready_reg;
    assign bus.load_done   = load_done_reg;
    assign bus.ram_ready   = ram_ready_reg;
    assign bus.addr_error  = addr_error_reg;
endmodule

// File: tb/tb_param_instr_ram.sv
// Bench for param_instr_ram (DEPTH=8): behavioural model checked every cycle plus literal checks.
module tb_param_instr_ram;
    localparam int          DW    = 32;
    localparam int          AW    = 4;
    localparam int          DEPTH = 8;
    localparam logic [31:0] NOP   = 32'h6C000000;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    param_instr_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    param_instr_ram #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .NOP_WORD(NOP)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp    = 0;
    int n_bad    = 0;
    int done_cnt = 0;
    bit chk_on   = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: memory as a plain array, mode 0 sweeping / 1 running / 2 loading.
    int          m_mode, m_swept, m_ptr, m_left;
    logic [31:0] m_mem [DEPTH];
    logic [31:0] e_fetch_data;
    logic        e_fetch_valid, e_load_ready, e_load_done, e_ram_ready, e_addr_error;

    task automatic model_step();
        int fa, wa, ba;
        if (!reset_n) begin
            m_mode = 0; m_swept = 0;
            e_fetch_data = NOP; e_fetch_valid = 0; e_load_ready = 0;
            e_load_done = 0; e_ram_ready = 0; e_addr_error = 0;
            return;
        end
        e_load_done   = 0;
        e_fetch_valid = 0;
        fa = int'(bus.fetch_address);
        wa = int'(bus.i_ram_writing_address);
        ba = int'(bus.load_base);
        if (m_mode == 0) begin
            m_mem[m_swept] = NOP;
            m_swept++;
            if (m_swept == DEPTH) m_mode = 1;
        end else if (m_mode == 1) begin
            if (bus.fetch_en) begin
                e_fetch_valid = 1;
                if (fa < DEPTH) begin
                    e_fetch_data = m_mem[fa];
`ifdef FETCH_BYPASS_EN
                    if (bus.flag_write_i_ram && wa == fa) e_fetch_data = bus.i_ram_input;
`endif
                end else begin
                    e_fetch_data = NOP;
                    e_addr_error = 1;
                end
            end
            if (bus.flag_write_i_ram) begin
                if (wa < DEPTH) m_mem[wa] = bus.i_ram_input;
                else e_addr_error = 1;
            end
            if (bus.load_start) begin
                if (ba >= DEPTH) begin
                    e_addr_error = 1;
                    e_load_done  = 1;
                end else if (bus.load_count == 0) begin
                    e_load_done = 1;
                end else begin
                    m_ptr = ba; m_left = int'(bus.load_count); m_mode = 2;
                end
            end
        end else begin
            if (bus.load_valid) begin
                m_mem[m_ptr] = bus.load_data;
                m_ptr = (m_ptr + 1) % DEPTH;
                m_left--;
                if (m_left == 0) begin
                    m_mode = 1;
                    e_load_done = 1;
                end
            end
        end
        e_ram_ready  = (m_mode == 1);
        e_load_ready = (m_mode == 2);
    endtask

    initial forever begin
        @(posedge clock or negedge reset_n);
        model_step();
    end

    initial forever begin
        @(negedge clock);
        if (bus.load_done === 1'b1) done_cnt++;
        if (chk_on) begin
            check("cyc_fetch_valid", 32'(bus.fetch_valid), 32'(e_fetch_valid));
            check("cyc_fetch_data",  bus.fetch_data,       e_fetch_data);
            check("cyc_load_ready",  32'(bus.load_ready),  32'(e_load_ready));
            check("cyc_load_done",   32'(bus.load_done),   32'(e_load_done));
            check("cyc_ram_ready",   32'(bus.ram_ready),   32'(e_ram_ready));
            check("cyc_addr_error",  32'(bus.addr_error),  32'(e_addr_error));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.fetch_en = 0; bus.fetch_address = '0;
        bus.load_start = 0; bus.load_base = '0; bus.load_count = '0;
        bus.load_data = '0; bus.load_valid = 0;
        bus.i_ram_writing_address = '0; bus.i_ram_input = '0; bus.flag_write_i_ram = 0;
    endtask

    task automatic fetch_chk(input int a, input logic [31:0] exp, input string nm);
        bus.fetch_en = 1; bus.fetch_address = AW'(a);
        tick();
        bus.fetch_en = 0;
        check({nm, "_valid"}, 32'(bus.fetch_valid), 32'd1);
        check({nm, "_data"}, bus.fetch_data, exp);
    endtask

    task automatic dwrite(input int a, input logic [31:0] d);
        bus.flag_write_i_ram = 1; bus.i_ram_writing_address = AW'(a); bus.i_ram_input = d;
        tick();
        bus.flag_write_i_ram = 0;
    endtask

    task automatic start_load(input int base, input int cnt);
        bus.load_start = 1; bus.load_base = AW'(base); bus.load_count = (AW+1)'(cnt);
        tick();
        bus.load_start = 0;
    endtask

    logic [31:0] stream_d [5] = '{32'hA0000000, 32'hA0000001, 32'h0, 32'hA0000002, 32'hA0000003};
    bit          stream_v [5] = '{1, 1, 0, 1, 1};
    logic [31:0] byp_exp;
    int          done_snap;

    initial begin
        idle_inputs();
        #1 reset_n = 0;
        #1 chk_on = 1;
        repeat (3) tick();
        check("rst_fetch_data", bus.fetch_data, NOP);
        check("rst_ram_ready", 32'(bus.ram_ready), 32'd0);
        reset_n = 1;
        // Sweep writes on edges 1..8; ram_ready is high from edge 8, i.e. in the 9th cycle.
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 7) check("ready_early", 32'(bus.ram_ready), 32'd0);
            if (i == 8) check("ready_cycle9", 32'(bus.ram_ready), 32'd1);
        end
        for (int i = 0; i < DEPTH; i++) fetch_chk(i, NOP, "sweep_nop");

        // Streaming load with wrap and a bubble.
        done_snap = done_cnt;
        start_load(6, 4);
        check("load_ready_up", 32'(bus.load_ready), 32'd1);
        check("load_ram_busy", 32'(bus.ram_ready), 32'd0);
        for (int k = 0; k < 5; k++) begin
            bus.load_valid = stream_v[k]; bus.load_data = stream_d[k];
            tick();
        end
        bus.load_valid = 0;
        check("load_done_pulse", 32'(bus.load_done), 32'd1);
        check("load_ready_drop", 32'(bus.load_ready), 32'd0);
        check("load_ram_back", 32'(bus.ram_ready), 32'd1);
        tick();
        check("load_done_once", 32'(done_cnt - done_snap), 32'd1);
        fetch_chk(6, 32'hA0000000, "ld_m6");
        fetch_chk(7, 32'hA0000001, "ld_m7");
        fetch_chk(0, 32'hA0000002, "ld_m0");
        fetch_chk(1, 32'hA0000003, "ld_m1");

        // Direct write, then one ignored while loading.
        dwrite(3, 32'hDEADBEEF);
        fetch_chk(3, 32'hDEADBEEF, "dw_m3");
        start_load(4, 2);
        dwrite(3, 32'h11111111);
        bus.load_valid = 1; bus.load_data = 32'hB0000000; tick();
        bus.load_data = 32'hB0000001; tick();
        bus.load_valid = 0;
        fetch_chk(3, 32'hDEADBEEF, "dw_ignored");
        fetch_chk(4, 32'hB0000000, "ld_m4");
        fetch_chk(5, 32'hB0000001, "ld_m5");

        // Same-cycle write and fetch.
        dwrite(2, 32'hCAFEF00D);
`ifdef FETCH_BYPASS_EN
        byp_exp = 32'h12345678;
`else
        byp_exp = 32'hCAFEF00D;
`endif
        bus.flag_write_i_ram = 1; bus.i_ram_writing_address = 4'd2; bus.i_ram_input = 32'h12345678;
        bus.fetch_en = 1; bus.fetch_address = 4'd2;
        tick();
        bus.flag_write_i_ram = 0; bus.fetch_en = 0;
        check("rw_same_cycle", bus.fetch_data, byp_exp);
        fetch_chk(2, 32'h12345678, "rw_after");

        // Zero-length load.
        start_load(1, 0);
        check("cnt0_done", 32'(bus.load_done), 32'd1);
        check("cnt0_no_err", 32'(bus.addr_error), 32'd0);
        tick();
        check("cnt0_done_low", 32'(bus.load_done), 32'd0);

        // Out-of-range fetch; error stays set.
        fetch_chk(12, NOP, "oor_fetch");
        check("oor_err", 32'(bus.addr_error), 32'd1);
        repeat (3) tick();
        check("oor_err_sticky", 32'(bus.addr_error), 32'd1);

        // Reset in the middle of a load.
        start_load(0, 4);
        bus.load_valid = 1; bus.load_data = 32'hC0000000; tick();
        bus.load_data = 32'hC0000001; tick();
        bus.load_valid = 0;
        done_snap = done_cnt;
        reset_n = 0;
        repeat (2) tick();
        check("abort_err_clr", 32'(bus.addr_error), 32'd0);
        check("abort_ready", 32'(bus.load_ready), 32'd0);
        reset_n = 1;
        repeat (8) tick();
        check("abort_ram_ready", 32'(bus.ram_ready), 32'd1);
        for (int i = 0; i < DEPTH; i++) fetch_chk(i, NOP, "abort_nop");
        check("abort_no_done", 32'(done_cnt - done_snap), 32'd0);

        // Load base out of range.
        start_load(9, 2);
        check("oor_base_done", 32'(bus.load_done), 32'd1);
        check("oor_base_err", 32'(bus.addr_error), 32'd1);
        check("oor_base_run", 32'(bus.ram_ready), 32'd1);

        // Out-of-range direct write must not alias onto a real word.
        reset_n = 0; tick(); reset_n = 1;
        repeat (8) tick();
        dwrite(15, 32'hBAD0BAD0);
        check("oor_dw_err", 32'(bus.addr_error), 32'd1);
        fetch_chk(7, NOP, "oor_dw_alias");

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/param_instr_ram.md
Name: param_instr_ram

Overview:
- Parametrised next-generation instruction memory for the Galetron core.
- Sits between the fetch stage and the program-load path.
- After reset, a hardware sweep fills the whole array with NOP.
- Provides a streaming valid/ready program loader with auto-increment and wrap, a legacy single-word direct write port, and a registered 1-cycle fetch port with valid flag and out-of-range protection.

Parameters:
- DATA_WIDTH, 32, instruction word width in bits.
- ADDR_WIDTH, 10, address width in bits.
- DEPTH, 1024, number of words; must satisfy 2 <= DEPTH <= 2**ADDR_WIDTH.
- NOP_WORD, 32'h6C000000, fill value for the clear sweep and for out-of-range reads.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fetch_en  in  1  request a fetch this cycle.
- fetch_address  in  ADDR_WIDTH  fetch word address.
- fetch_data  out  DATA_WIDTH  registered fetch result.
- fetch_valid  out  1  fetch_data is valid this cycle.
- load_start  in  1  pulse that starts a streaming load.
- load_base  in  ADDR_WIDTH  first load address; sampled with load_start.
- load_count  in  ADDR_WIDTH+1  number of words to load; sampled with load_start.
- load_data  in  DATA_WIDTH  stream word.
- load_valid  in  1  load_data is valid.
- load_ready  out  1  block accepts a stream word.
- load_done  out  1  1-cycle pulse when a load completes.
- i_ram_writing_address  in  ADDR_WIDTH  direct write address.
- i_ram_input  in  DATA_WIDTH  direct write data.
- flag_write_i_ram  in  1  direct write enable.
- ram_ready  out  1  high in the RUN state.
- addr_error  out  1  sticky out-of-range flag.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=CLEAR, clear_ptr=0.
  - fetch_data=NOP_WORD; fetch_valid, load_ready, load_done, ram_ready and addr_error are all 0.
  - Memory contents are not reset asynchronously.
- CLEAR:
  - Each cycle writes NOP_WORD to mem[clear_ptr], then clear_ptr++.
  - After the write at DEPTH-1, go to RUN. The sweep takes exactly DEPTH cycles, and ram_ready=1 on the following cycle.
  - Fetch, load and direct writes are ignored. fetch_valid=0, load_ready=0.
- RUN:
  - ram_ready=1.
  - load_start with load_base<DEPTH and load_count>0: latch ptr=load_base and remaining=load_count, then go to LOAD.
  - load_start with load_count=0: load_done pulses next cycle; stay in RUN.
  - load_start with load_base>=DEPTH: set addr_error, pulse load_done, stay in RUN.
  - Direct write with flag_write_i_ram=1: writes mem[i_ram_writing_address] at the edge. If the address is >=DEPTH, the write is dropped and addr_error is set.
  - If a direct write and load_start occur in the same cycle, both take effect.
- LOAD:
  - ram_ready=0, load_ready=1.
  - On load_valid&load_ready: write mem[ptr]=load_data and decrement remaining.
  - ptr advances with wrap: DEPTH-1 -> 0.
  - The write that brings remaining to 0 moves the state to RUN. load_ready drops and load_done pulses on the next cycle.
  - Direct writes and load_start are ignored in LOAD.
  - load_valid low stalls the load indefinitely with no timeout.
- Fetch (RUN only):
  - fetch_en=1 with fetch_address<DEPTH: next cycle fetch_data=mem[addr] and fetch_valid=1.
  - fetch_address>=DEPTH: fetch_data=NOP_WORD, fetch_valid=1, addr_error set.
  - fetch_en=0, or any cycle not in RUN: fetch_valid=0 and fetch_data holds its last value.
  - Read and write to the same address in the same cycle return the old data (read-before-write).
- Reset asserted mid-LOAD or mid-CLEAR aborts the operation. The block restarts in CLEAR from address 0.
- addr_error is cleared only by reset.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined: a same-cycle write (direct or load) to the fetched address forwards the write data, so fetch_data is the new word. A load write takes priority over a direct write.
- Undefined: read-before-write; fetch_data is the old word.

Test Plan:
- Reset with DEPTH=8, then release: ram_ready rises exactly 9 cycles after release; fetching each of addresses 0..7 returns 32'h6C000000 with fetch_valid=1 one cycle later.
- load_start with base=6, count=4 and a stream of A0..A3 with a bubble between A1 and A2: mem[6]=A0, mem[7]=A1, mem[0]=A2, mem[1]=A3; load_done pulses once; ram_ready returns.
- Direct write 0xDEADBEEF to addr 3, then fetch addr 3: fetch_data=0xDEADBEEF next cycle. The same direct write during LOAD is ignored, and mem[3] is unchanged.
- Fetch addr 12 with DEPTH=8: fetch_data=NOP_WORD, fetch_valid=1, addr_error=1 and it stays 1 until reset.
- Same-cycle direct write of 0x12345678 and fetch at addr 2, where mem[2] previously held X: fetch returns X without FETCH_BYPASS_EN, and 0x12345678 with it.
- reset_n pulsed low after 2 of 4 load words: load aborts, CLEAR restarts, all words are NOP afterwards, and load_done never pulses.
